// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, controller states, default operand width and op decode helpers.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  // Divide ops share the upper encoding bit
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  // MULT and DIV treat their operands as two's complement
  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negator. Used to take operand magnitudes
// before iterating and to restore result signs afterwards.
module muldiv_abs
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // Pass through, or invert-and-increment when negation is requested
  always_comb begin
    result = negate ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Signed operands are reduced to magnitudes in PREP, one shift-add or
// restoring-subtract step runs per cycle in RUN, and FIX restores signs
// and publishes hi/lo.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN
// as soon as the remaining multiplier bits are all zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q;
  state_e               state_d;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mq_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 dbz_q;

  logic                 neg_a;
  logic                 neg_b;
  logic                 neg_quot;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_take;
  logic [WIDTH-1:0]     div_rem;
  logic                 mul_early;
  logic                 last_iter;

  assign neg_a    = op_is_signed(op_q) & a_q[WIDTH-1];
  assign neg_b    = op_is_signed(op_q) & b_q[WIDTH-1];
  assign neg_quot = neg_a ^ neg_b;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value  (a_q),
    .negate (neg_a),
    .result (a_mag)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value  (b_q),
    .negate (neg_b),
    .result (b_mag)
  );

  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value  (acc_q),
    .negate (neg_quot),
    .result (prod_fix)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_quot (
    .value  (acc_q[WIDTH-1:0]),
    .negate (neg_quot),
    .result (quot_fix)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (acc_q[2*WIDTH-1:WIDTH]),
    .negate (neg_a),
    .result (rem_fix)
  );

  // One iteration of each algorithm: shift-add product accumulate, and a
  // restoring trial subtract of the divisor from the shifted partial remainder
  always_comb begin
    mul_sum   = acc_q + (mq_q[0] ? mcand_q : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
    div_take  = ~div_diff[WIDTH];
    div_rem   = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_early = !op_is_div(op_q) && (mq_q[WIDTH-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_LAST) || mul_early;

  // Controller state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel wins over everything while busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = cancel ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (cancel)         state_d = ST_IDLE;
        else if (last_iter) state_d = ST_FIX;
      end
      ST_FIX:  state_d = cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = start ? ST_PREP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
  end

  // Datapath: latch request, load magnitudes, iterate, then sign-fix results
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_q <= op_e'(op);
            a_q  <= a;
            b_q  <= b;
          end
        end
        ST_PREP: begin
          cnt_q <= '0;
          if (op_is_div(op_q)) begin
            acc_q   <= {{WIDTH{1'b0}}, a_mag};
            mcand_q <= {{WIDTH{1'b0}}, b_mag};
            mq_q    <= '0;
          end else begin
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_mag};
            mq_q    <= b_mag;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_is_div(op_q)) begin
            acc_q <= {div_rem, acc_q[WIDTH-2:0], div_take};
          end else begin
            acc_q   <= mul_sum;
            mcand_q <= mcand_q << 1;
            mq_q    <= mq_q >> 1;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            if (!op_is_div(op_q)) begin
              hi_q  <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q  <= prod_fix[WIDTH-1:0];
              dbz_q <= 1'b0;
            end else if (b_q == '0) begin
              hi_q  <= a_q;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else begin
              hi_q  <= rem_fix;
              lo_q  <= quot_fix;
              dbz_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: directed vectors with
// literal expectations, then randomized traffic (including cancels, resets
// and starts while busy) checked every cycle against a behavioural model.
// Honours MULDIV_EARLY_OUT_EN for multiply latency expectations.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  bit           checking_en = 1'b0;
  bit           model_busy  = 1'b0;
  bit           model_done  = 1'b0;
  int           model_left  = 0;
  logic [64:0]  model_pend  = '0;
  logic [W-1:0] exp_hi      = '0;
  logic [W-1:0] exp_lo      = '0;
  logic         exp_dbz     = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic reference: {div_by_zero, hi, lo}
  function automatic logic [64:0] refResult(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = 64'(sx * sy);
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        return {1'b0, p};
      end
      2'b10: begin
        if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (y == '0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Edges from the start-sampling edge to the one that raises done
  function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] y);
    logic [W-1:0] m;
    int           n;
    m = (o == 2'b00 && y[W-1]) ? (~y + 32'd1) : y;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    if (o[1]) return W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    return 2 + n;
`else
    return (n > 0) ? W + 2 : W + 2;
`endif
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      5:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: an accepted op completes a fixed number of edges later
  // unless cancelled or reset; results are held until the next completion
  always @(posedge clk) begin
    if (!rst) begin
      model_busy <= 1'b0;
      model_done <= 1'b0;
      exp_hi     <= '0;
      exp_lo     <= '0;
      exp_dbz    <= 1'b0;
    end else if (model_busy) begin
      model_done <= 1'b0;
      if (cancel) begin
        model_busy <= 1'b0;
      end else if (model_left == 0) begin
        model_busy <= 1'b0;
        model_done <= 1'b1;
        exp_dbz    <= model_pend[64];
        exp_hi     <= model_pend[63:32];
        exp_lo     <= model_pend[31:0];
      end else begin
        model_left <= model_left - 1;
      end
    end else begin
      model_done <= 1'b0;
      if (start) begin
        model_busy <= 1'b1;
        model_left <= refLatency(op, b) - 1;
        model_pend <= refResult(op, a, b);
      end
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge
  always @(negedge clk) begin
    if (checking_en) begin
      checkOutput("busy", 64'(busy), 64'(model_busy));
      checkOutput("done", 64'(done), 64'(model_done));
      checkOutput("hi", 64'(hi), 64'(exp_hi));
      checkOutput("lo", 64'(lo), 64'(exp_lo));
      if (model_done) checkOutput("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
    end
  end

  // Issue one op from IDLE/DONE and wait (bounded) for its done pulse
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, output int lat);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Start an op and abort it with cancel or reset after edge 10
  task automatic applyAbort(input bit use_reset);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'h0000_1000;
    b     = 32'h0000_0003;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    if (use_reset) rst = 1'b0;
    else           cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    rst    = 1'b1;
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [W-1:0] early_lat;

    rst    = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    @(posedge clk); #1;
    checking_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checkOutput("multu_max_latency", 64'(lat), 64'd34);
    checkOutput("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    checkOutput("multu_max_lo", 64'(lo), 64'h0000_0001);
    checkOutput("busy_with_done", 64'(busy), 64'd0);

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat);
    checkOutput("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);

    applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0002, lat);
    checkOutput("divu_lo", 64'(lo), 64'h3);
    checkOutput("divu_hi", 64'(hi), 64'h1);

    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    checkOutput("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checkOutput("div_ovf_lo", 64'(lo), 64'h8000_0000);
    checkOutput("div_ovf_hi", 64'(hi), 64'h0);
    checkOutput("div_ovf_dbz", 64'(div_by_zero), 64'd0);

    applyStimulus(2'b10, 32'h1234_5678, 32'h0000_0000, lat);
    checkOutput("div0_latency", 64'(lat), 64'd34);
    checkOutput("div0_dbz", 64'(div_by_zero), 64'd1);
    checkOutput("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("div0_hi", 64'(hi), 64'h1234_5678);

`ifdef MULDIV_EARLY_OUT_EN
    early_lat = 32'd4;
`else
    early_lat = 32'd34;
`endif
    applyStimulus(2'b01, 32'h0000_0005, 32'h0000_0003, lat);
    checkOutput("multu_small_latency", 64'(lat), 64'(early_lat));
    checkOutput("multu_small_hi", 64'(hi), 64'h0);
    checkOutput("multu_small_lo", 64'(lo), 64'hF);

    applyStimulus(2'b01, 32'h0000_1234, 32'h0000_0010, lat);
    checkOutput("prior_lo", 64'(lo), 64'h0001_2340);
    applyAbort(1'b0);
    checkOutput("cancel_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checkOutput("cancel_no_done", 64'(done_seen), 64'd0);
    checkOutput("cancel_hi_kept", 64'(hi), 64'h0);
    checkOutput("cancel_lo_kept", 64'(lo), 64'h0001_2340);

    applyAbort(1'b1);
    checkOutput("midop_reset_busy", 64'(busy), 64'd0);
    checkOutput("midop_reset_hi", 64'(hi), 64'd0);
    checkOutput("midop_reset_lo", 64'(lo), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) == 0);
      op     = 2'($urandom_range(0, 3));
      a      = pickOperand();
      b      = pickOperand();
      cancel = ($urandom_range(0, 59) == 0);
      rst    = ($urandom_range(0, 399) != 0);
    end
    @(posedge clk); #1;
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
